axi_w_dest_router: RTL and testbench

Write-data (W) channel router for the AXI node's target-side slave port. It queues one destination entry per accepted AW burst and steers W beats to the selected initiator port, in AW order. It sinks the beats of decode-error bursts per transaction, instead of through a global error mode, and optionally checks burst length against AWLEN. It sits between the AW address decoder, which pushes entries, and the per-initiator W arbiters.

---
 rtl/axi_w_router_pkg.sv | 28 ++
 rtl/axi_w_dest_fifo.sv | 60 ++++++
 rtl/axi_w_dest_router.sv | 123 ++++++++++++
 tb/tb_axi_w_dest_router.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_w_router_pkg.sv
// Shared types and helpers for the AXI W-channel destination router.
// Entry layouts cover both builds: with AXI_W_LEN_CHECK_EN (len field present) and without.
package axi_w_router_pkg;

  localparam int N_INIT_PORT_DEF = 4;
  localparam int AXI_LEN_W_DEF   = 8;
  localparam int ONEHOT_MAX_W    = 64;

  typedef struct packed {
    logic                       err;
    logic [N_INIT_PORT_DEF-1:0] dest;
    logic [AXI_LEN_W_DEF-1:0]   len;
  } w_dest_len_entry_t;

  typedef struct packed {
    logic                       err;
    logic [N_INIT_PORT_DEF-1:0] dest;
  } w_dest_entry_t;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/axi_w_dest_fifo.sv
// Registered destination FIFO with occupancy count; no fall-through, no pass-through.
// Data storage is not reset; only pointers and count are.
module axi_w_dest_fifo
  import axi_w_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      test_en_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [count_w(DEPTH)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic             unused_test_en;

  assign unused_test_en = test_en_i;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_w_dest_router.sv
// W-channel router: steers W beats to the initiator chosen by the AW-ordered head entry,
// sinks decode-error bursts. Optional burst-length checker under `AXI_W_LEN_CHECK_EN.
module axi_w_dest_router
  import axi_w_router_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int AXI_LEN_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           test_en_i,
  input  logic                           push_dest_i,
  input  logic [N_INIT_PORT-1:0]         dest_i,
  input  logic                           err_i,
  input  logic [AXI_LEN_W-1:0]           len_i,
  output logic                           dest_grant_o,
  input  logic                           wvalid_i,
  input  logic                           wlast_i,
  output logic                           wready_o,
  output logic [N_INIT_PORT-1:0]         wvalid_o,
  input  logic [N_INIT_PORT-1:0]         wready_i,
  output logic                           err_done_o,
`ifdef AXI_W_LEN_CHECK_EN
  output logic                           len_err_o,
`endif
  output logic [count_w(FIFO_DEPTH)-1:0] fifo_count_o
);

`ifdef AXI_W_LEN_CHECK_EN
  typedef struct packed {
    logic                   err;
    logic [N_INIT_PORT-1:0] dest;
    logic [AXI_LEN_W-1:0]   len;
  } entry_t;
`else
  typedef struct packed {
    logic                   err;
    logic [N_INIT_PORT-1:0] dest;
  } entry_t;
`endif

  entry_t push_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   head_vld;
  logic   beat_acc;
  logic   pop;

  always_comb begin
    push_entry      = '0;
    push_entry.err  = err_i;
    push_entry.dest = dest_i;
`ifdef AXI_W_LEN_CHECK_EN
    push_entry.len  = len_i;
`endif
  end

  axi_w_dest_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .test_en_i(test_en_i),
    .push_i   (push_dest_i),
    .data_i   (push_entry),
    .pop_i    (pop),
    .data_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count_o)
  );

  assign dest_grant_o = ~fifo_full;
  assign head_vld     = ~fifo_empty;

  // Head decode: error heads accept and discard beats, normal heads forward to dest
  always_comb begin
    wvalid_o   = '0;
    wready_o   = 1'b0;
    err_done_o = 1'b0;
    if (head_vld) begin
      if (head.err) begin
        wready_o   = 1'b1;
        err_done_o = wvalid_i & wlast_i;
      end else begin
        wvalid_o = {N_INIT_PORT{wvalid_i}} & head.dest;
        wready_o = |(wready_i & head.dest);
      end
    end
  end

  assign beat_acc = wvalid_i & wready_o;
  assign pop      = beat_acc & wlast_i;

`ifdef AXI_W_LEN_CHECK_EN
  logic [AXI_LEN_W-1:0] beat_cnt;
  logic                 len_viol;

  assign len_viol = beat_acc & (wlast_i != (beat_cnt == head.len));

  // Counter saturates so an over-long burst keeps flagging instead of wrapping to a match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      len_err_o <= 1'b0;
    end else begin
      len_err_o <= len_viol;
      if (pop)                              beat_cnt <= '0;
      else if (beat_acc && beat_cnt != '1)  beat_cnt <= beat_cnt + 1'b1;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  a_dest_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (push_dest_i && dest_grant_o && !err_i) |-> is_onehot(ONEHOT_MAX_W'(dest_i)));

endmodule

// File: tb/tb_axi_w_dest_router.sv
// Randomized + directed bench for axi_w_dest_router against a queue-based reference model.
// Build with or without AXI_W_LEN_CHECK_EN.
module tb_axi_w_dest_router;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int L  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          test_en;
  logic          push_dest;
  logic [N-1:0]  dest;
  logic          err;
  logic [L-1:0]  len;
  logic          dest_grant;
  logic          wvalid_in;
  logic          wlast;
  logic          wready_out;
  logic [N-1:0]  wvalid_out;
  logic [N-1:0]  wready_in;
  logic          err_done;
  logic          len_err;
  logic [CW-1:0] fifo_count;

  axi_w_dest_router #(
    .N_INIT_PORT(N),
    .FIFO_DEPTH (D),
    .AXI_LEN_W  (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_en_i   (test_en),
    .push_dest_i (push_dest),
    .dest_i      (dest),
    .err_i       (err),
    .len_i       (len),
    .dest_grant_o(dest_grant),
    .wvalid_i    (wvalid_in),
    .wlast_i     (wlast),
    .wready_o    (wready_out),
    .wvalid_o    (wvalid_out),
    .wready_i    (wready_in),
    .err_done_o  (err_done),
`ifdef AXI_W_LEN_CHECK_EN
    .len_err_o   (len_err),
`endif
    .fifo_count_o(fifo_count)
  );

`ifndef AXI_W_LEN_CHECK_EN
  assign len_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: queue of outstanding bursts plus beats seen on the head burst
  typedef struct {
    bit         err;
    bit [N-1:0] dest;
    int         len;
  } ent_t;

  ent_t q[$];
  int   beat      = 0;
  bit   viol_prev = 1'b0;

  function automatic int sat_beat();
    return (beat > (1 << L) - 1) ? (1 << L) - 1 : beat;
  endfunction

  // Inputs are already applied (posedge+1); check at the falling edge, then advance one cycle
  task automatic step();
    bit         exp_rdy;
    bit [N-1:0] exp_vld;
    bit         exp_done;
    bit         acc, pop, push_ok, viol;
    ent_t       e;
    #4;
    exp_rdy  = 1'b0;
    exp_vld  = '0;
    exp_done = 1'b0;
    if (q.size() > 0) begin
      if (q[0].err) begin
        exp_rdy  = 1'b1;
        exp_done = wvalid_in && wlast;
      end else begin
        exp_rdy = (wready_in & q[0].dest) != 0;
        exp_vld = wvalid_in ? q[0].dest : '0;
      end
    end
    chk("wready", 64'(wready_out), 64'(exp_rdy));
    chk("wvalid", 64'(wvalid_out), 64'(exp_vld));
    chk("err_done", 64'(err_done), 64'(exp_done));
    chk("grant", 64'(dest_grant), 64'(q.size() < D));
    chk("count", 64'(fifo_count), 64'(q.size()));
`ifdef AXI_W_LEN_CHECK_EN
    chk("len_err", 64'(len_err), 64'(viol_prev));
`endif
    acc     = wvalid_in && exp_rdy;
    pop     = acc && wlast;
    push_ok = push_dest && (q.size() < D);
    viol    = acc && (wlast != (sat_beat() == q[0].len));
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      beat = 0;
    end else if (acc) begin
      beat++;
    end
    if (push_ok) begin
      e.err  = err;
      e.dest = dest;
      e.len  = int'(len);
      q.push_back(e);
    end
    viol_prev = viol;
    #1;
  endtask

  task automatic idle_in();
    push_dest = 1'b0;
    dest      = '0;
    err       = 1'b0;
    len       = '0;
    wvalid_in = 1'b0;
    wlast     = 1'b0;
    wready_in = '0;
  endtask

  task automatic set_push(input bit e, input bit [N-1:0] d, input int ln);
    push_dest = 1'b1;
    err       = e;
    dest      = d;
    len       = L'(ln);
  endtask

  task automatic drain();
    int guard = 0;
    idle_in();
    while (q.size() > 0 && guard < 200) begin
      wvalid_in = 1'b1;
      wready_in = '1;
      wlast     = (sat_beat() >= q[0].len);
      step();
      guard++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
    idle_in();
    step();
  endtask

  initial begin
    test_en = 1'b0;
    rst_n   = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_grant", 64'(dest_grant), 64'd1);
    chk("rst_wready", 64'(wready_out), 64'd0);
    chk("rst_wvalid", 64'(wvalid_out), 64'd0);
    chk("rst_err_done", 64'(err_done), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal burst of 4 beats to port 1
    set_push(1'b0, 4'b0010, 3);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      wvalid_in = 1'b1;
      wready_in = 4'b0010;
      wlast     = (i == 3);
      step();
    end
    idle_in();
    step();

    // Error burst, 2 beats, no downstream ready
    set_push(1'b1, 4'b0101, 1);
    step();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      wvalid_in = 1'b1;
      wlast     = (i == 1);
      step();
    end
    idle_in();
    step();

    // Fill, then push while popping: the push must be refused
    for (int i = 0; i < D; i++) begin
      set_push(1'b0, N'(1 << (i % N)), 0);
      step();
    end
    idle_in();
    step();
    chk("full_count", 64'(fifo_count), 64'(D));
    chk("full_grant", 64'(dest_grant), 64'd0);
    set_push(1'b0, 4'b0100, 0);
    wvalid_in = 1'b1;
    wlast     = 1'b1;
    wready_in = '1;
    step();
    idle_in();
    step();
    chk("full_pop_count", 64'(fifo_count), 64'(D - 1));
    drain();

    // Beats before their AW are held off; forwarding starts the cycle after the push
    wvalid_in = 1'b1;
    wlast     = 1'b1;
    wready_in = 4'b1000;
    step();
    set_push(1'b0, 4'b1000, 0);
    step();
    push_dest = 1'b0;
    step();
    idle_in();
    step();

    // Short burst: wlast on beat 2 for len=2
    set_push(1'b0, 4'b0001, 2);
    step();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      wvalid_in = 1'b1;
      wready_in = 4'b0001;
      wlast     = (i == 1);
      step();
    end
    idle_in();
    step();
    step();

    // Reset in the middle of a burst
    set_push(1'b0, 4'b0100, 3);
    step();
    idle_in();
    wvalid_in = 1'b1;
    wready_in = 4'b0100;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_wvalid", 64'(wvalid_out), 64'd0);
    chk("midrst_grant", 64'(dest_grant), 64'd1);
    chk("midrst_len_err", 64'(len_err), 64'd0);
    q.delete();
    beat      = 0;
    viol_prev = 1'b0;
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      push_dest = ($urandom_range(0, 2) == 0);
      err       = ($urandom_range(0, 4) == 0);
      dest      = err ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
      len       = L'($urandom_range(0, 3));
      wvalid_in = ($urandom_range(0, 2) != 0);
      wready_in = N'($urandom);
      if (q.size() > 0) wlast = (sat_beat() == q[0].len) ^ ($urandom_range(0, 9) == 0);
      else              wlast = 1'($urandom);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
